index_vector_decoder: RTL and testbench

- Inverse of the priority encoder.
- Accepts a stream of encoded bit indices (one per beat, framed by in_last) and rebuilds the NUM_OUTPUTS-bit vector they describe.
- Emits each rebuilt vector on a registered valid/ready output.
- Sits downstream of any logic that serialises a vector into indices by repeated priority encoding; restores the original mask at the far end.

---
 rtl/index_vector_decoder.sv | 198 +++++++++++++++++++
 tb/tb_index_vector_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/index_vector_decoder.sv
// ---------------------------------------------------------------------------
// index_vector_decoder
//
// Rebuilds an NUM_OUTPUTS-bit mask from a stream of bit indices, one index
// per beat, with the frame closed by in_last. This undoes a serialiser that
// walks a vector by repeated priority encoding. Each rebuilt vector is
// presented on a single-slot registered valid/ready output.
//
// Parameters:
//   NUM_OUTPUTS  width of the rebuilt vector (>= 2)
//   INDEX_WIDTH  width of in_index, derived, leave at default
//   COUNT_WIDTH  width of out_count, derived, leave at default
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            synchronous active-high reset
//   in_valid       in_index / in_last valid
//   in_ready       beat can be accepted (combinational)
//   in_index       bit position to set
//   in_last        final beat of the frame
//   out_valid      out_* fields valid
//   out_ready      consumer accepts the output
//   out_vector     rebuilt vector
//   out_count      number of distinct bits set in out_vector
//   out_range_err  frame contained an index >= NUM_OUTPUTS
//   out_dup_err    frame hit an already-set bit
//                  (only with INDEX_VECTOR_DECODER_DUP_ERR_EN)
//
// Optional feature macro: INDEX_VECTOR_DECODER_DUP_ERR_EN
//
// state  | meaning
// -------+------------------------------------------
// IDLE   | no frame open, next beat starts a frame
// ACTIVE | frame open, beats accumulate until in_last
// ---------------------------------------------------------------------------
module index_vector_decoder #(
  parameter int NUM_OUTPUTS = 16,
  parameter int INDEX_WIDTH = $clog2(NUM_OUTPUTS),
  parameter int COUNT_WIDTH = $clog2(NUM_OUTPUTS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INDEX_WIDTH-1:0] in_index,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_OUTPUTS-1:0] out_vector,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   out_range_err
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
  ,
  output logic                   out_dup_err
`endif
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Indices can only exceed NUM_OUTPUTS-1 when NUM_OUTPUTS is not a power
  // of two; one extra bit keeps the compare exact for every legal size.
  localparam logic [INDEX_WIDTH:0] INDEX_LIMIT = NUM_OUTPUTS[INDEX_WIDTH:0];

  state_t state_q;
  state_t state_d;

  logic [NUM_OUTPUTS-1:0] acc_q;
  logic [COUNT_WIDTH-1:0] acc_count_q;
  logic                   acc_err_q;

  logic                   accept;
  logic                   frame_end;
  logic                   in_range;
  logic [NUM_OUTPUTS-1:0] hit;
  logic                   new_bit;
  logic [NUM_OUTPUTS-1:0] acc_d;
  logic [COUNT_WIDTH-1:0] acc_count_d;
  logic                   acc_err_d;

`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
  logic acc_dup_q;
  logic acc_dup_d;
`endif

  assign in_ready  = !rst && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign frame_end = accept && in_last;

  // One-hot of the incoming index; an out-of-range index decodes to zero so
  // it contributes nothing to the vector or the count.
  always_comb begin
    in_range = ({1'b0, in_index} < INDEX_LIMIT);
    hit      = '0;
    for (int i = 0; i < NUM_OUTPUTS; i++) begin
      if (in_range && (in_index == INDEX_WIDTH'(i))) begin
        hit[i] = 1'b1;
      end
    end
  end

  // Next accumulator values including the current beat. These are what the
  // output register captures on the last beat, so the last index is counted.
  always_comb begin
    new_bit     = |(hit & ~acc_q);
    acc_d       = acc_q | hit;
    acc_count_d = acc_count_q + {{(COUNT_WIDTH-1){1'b0}}, new_bit};
    acc_err_d   = acc_err_q | !in_range;
  end

`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
  always_comb begin
    acc_dup_d = acc_dup_q | (|(hit & acc_q));
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && !in_last) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      acc_count_q <= '0;
      acc_err_q   <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc_q       <= '0;
        acc_count_q <= '0;
        acc_err_q   <= 1'b0;
      end else begin
        acc_q       <= acc_d;
        acc_count_q <= acc_count_d;
        acc_err_q   <= acc_err_d;
      end
    end
  end

  // Output slot. A new result may replace one being consumed in the same
  // cycle, which keeps single-beat frames flowing at one per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_vector    <= '0;
      out_count     <= '0;
      out_range_err <= 1'b0;
    end else begin
      if (frame_end) begin
        out_valid     <= 1'b1;
        out_vector    <= acc_d;
        out_count     <= acc_count_d;
        out_range_err <= acc_err_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_dup_q   <= 1'b0;
      out_dup_err <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        acc_dup_q   <= 1'b0;
        out_dup_err <= acc_dup_d;
      end else begin
        acc_dup_q   <= acc_dup_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_index_vector_decoder.sv
// ---------------------------------------------------------------------------
// tb_index_vector_decoder
//
// Two decoders share one input stream: a 16-output instance and a 10-output
// instance (both take 4-bit indices), so indices 10..15 exercise the range
// error path on the second one. A frame-level reference model collects the
// accepted indices of each frame and derives vector, count and flags.
// ---------------------------------------------------------------------------
module tb_index_vector_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_index = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready16, out_valid16, range16;
  logic [15:0] vec16;
  logic [4:0]  cnt16;
  logic        in_ready10, out_valid10, range10;
  logic [9:0]  vec10;
  logic [3:0]  cnt10;
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
  logic        dup16, dup10;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  index_vector_decoder #(.NUM_OUTPUTS(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready16),
    .in_index(in_index), .in_last(in_last),
    .out_valid(out_valid16), .out_ready(out_ready),
    .out_vector(vec16), .out_count(cnt16), .out_range_err(range16)
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
    , .out_dup_err(dup16)
`endif
  );

  index_vector_decoder #(.NUM_OUTPUTS(10)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready10),
    .in_index(in_index), .in_last(in_last),
    .out_valid(out_valid10), .out_ready(out_ready),
    .out_vector(vec10), .out_count(cnt10), .out_range_err(range10)
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
    , .out_dup_err(dup10)
`endif
  );

  // reference model state
  int          frame_q[$];
  bit          exp_valid = 1'b0;
  logic [31:0] e16_vec, e10_vec;
  int          e16_cnt, e10_cnt;
  bit          e16_err, e10_err, e16_dup, e10_dup;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void frame_result(input int n, input int q[$],
                                       output logic [31:0] vec, output int cnt,
                                       output bit err, output bit dup);
    vec = '0;
    err = 1'b0;
    dup = 1'b0;
    foreach (q[i]) begin
      if (q[i] >= n) begin
        err = 1'b1;
      end else begin
        if (vec[q[i]]) dup = 1'b1;
        vec[q[i]] = 1'b1;
      end
    end
    cnt = $countones(vec);
  endfunction

  task automatic check_outputs();
    chk("out_valid16", {31'd0, out_valid16}, {31'd0, exp_valid});
    chk("out_valid10", {31'd0, out_valid10}, {31'd0, exp_valid});
    if (exp_valid) begin
      chk("vec16", {16'd0, vec16}, e16_vec);
      chk("cnt16", {27'd0, cnt16}, e16_cnt);
      chk("rerr16", {31'd0, range16}, {31'd0, e16_err});
      chk("vec10", {22'd0, vec10}, e10_vec);
      chk("cnt10", {28'd0, cnt10}, e10_cnt);
      chk("rerr10", {31'd0, range10}, {31'd0, e10_err});
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
      chk("dup16", {31'd0, dup16}, {31'd0, e16_dup});
      chk("dup10", {31'd0, dup10}, {31'd0, e10_dup});
`endif
    end
  endtask

  // One clock: drive, check in_ready before the edge, advance model, check after.
  task automatic cycle(input bit v, input int idx, input bit last, input bit ordy);
    bit exp_rdy;
    in_valid  = v;
    in_index  = 4'(idx);
    in_last   = last;
    out_ready = ordy;
    #1;
    exp_rdy = !exp_valid || ordy;
    chk("in_ready16", {31'd0, in_ready16}, {31'd0, exp_rdy});
    chk("in_ready10", {31'd0, in_ready10}, {31'd0, exp_rdy});
    if (v && exp_rdy && last) begin
      frame_q.push_back(idx);
      frame_result(16, frame_q, e16_vec, e16_cnt, e16_err, e16_dup);
      frame_result(10, frame_q, e10_vec, e10_cnt, e10_err, e10_dup);
      frame_q.delete();
      exp_valid = 1'b1;
    end else begin
      if (v && exp_rdy) frame_q.push_back(idx);
      if (ordy) exp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_in_ready16", {31'd0, in_ready16}, 32'd0);
      chk("rst_in_ready10", {31'd0, in_ready10}, 32'd0);
    end
    chk("rst_valid16", {31'd0, out_valid16}, 32'd0);
    chk("rst_vec16", {16'd0, vec16}, 32'd0);
    chk("rst_cnt16", {27'd0, cnt16}, 32'd0);
    chk("rst_rerr16", {31'd0, range16}, 32'd0);
    chk("rst_valid10", {31'd0, out_valid10}, 32'd0);
    rst = 1'b0;
    frame_q.delete();
    exp_valid = 1'b0;
  endtask

  logic [15:0] held;

  initial begin
    do_reset(2);

    // reset in the middle of a frame discards the partial accumulator
    cycle(1, 2, 0, 1);
    cycle(1, 5, 0, 1);
    do_reset(3);
    cycle(1, 7, 1, 1);
    chk("rstmid_vec", {16'd0, vec16}, 32'h0080);
    chk("rstmid_cnt", {27'd0, cnt16}, 32'd1);

    // multi-beat frame
    cycle(1, 15, 0, 1);
    cycle(1, 9, 0, 1);
    cycle(1, 0, 1, 1);
    chk("mb_vec", {16'd0, vec16}, 32'h8201);
    chk("mb_cnt", {27'd0, cnt16}, 32'd3);
    chk("mb_rerr", {31'd0, range16}, 32'd0);
    cycle(0, 0, 0, 1);

    // backpressure: full slot that is not draining blocks new beats
    cycle(1, 3, 1, 0);
    held = vec16;
    for (int i = 0; i < 3; i++) cycle(1, 4, 0, 0);
    chk("bp_hold_vec", {16'd0, vec16}, {16'd0, held});
    chk("bp_hold_val", {16'd0, vec16}, 32'h0008);
    cycle(1, 4, 0, 1);
    cycle(1, 6, 0, 1);
    cycle(1, 8, 1, 1);
    chk("bp_vec", {16'd0, vec16}, 32'h0150);
    chk("bp_cnt", {27'd0, cnt16}, 32'd3);

    // back-to-back single-beat frames at full rate
    for (int i = 0; i < 8; i++) begin
      cycle(1, i, 1, 1);
      chk("tp_vec", {16'd0, vec16}, 32'd1 << i);
    end
    cycle(0, 0, 0, 1);

    // range error on the 10-output instance
    cycle(1, 12, 0, 1);
    cycle(1, 4, 1, 1);
    chk("re_vec10", {22'd0, vec10}, 32'h010);
    chk("re_cnt10", {28'd0, cnt10}, 32'd1);
    chk("re_err10", {31'd0, range10}, 32'd1);
    cycle(1, 1, 1, 1);
    chk("re_clr10", {31'd0, range10}, 32'd0);

    // duplicates
    cycle(1, 5, 0, 1);
    cycle(1, 5, 0, 1);
    cycle(1, 5, 1, 1);
    chk("dup_vec", {16'd0, vec16}, 32'h0020);
    chk("dup_cnt", {27'd0, cnt16}, 32'd1);
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
    chk("dup_flag", {31'd0, dup16}, 32'd1);
`endif
    cycle(1, 5, 1, 1);
`ifdef INDEX_VECTOR_DECODER_DUP_ERR_EN
    chk("dup_clr", {31'd0, dup16}, 32'd0);
`endif

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(int'($urandom_range(1, 3)));
      end else begin
        cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
